aes_ctr_slice_reg: RTL
======================

Name: aes_ctr_slice_reg

Overview:
- Counter storage and sequencing stage for AES CTR mode. Sits between the AES main control and the sliced counter-increment FSM.
- Holds the 128-bit counter and loads it from the IV. Accepts increment requests and launches the FSM, then serves and absorbs counter slices by index.
- Acknowledges the requester once all slices have been written back.

Parameters:
- NumSlices, 8, number of counter slices; must be a power of two.
- SliceSize, 16, bits per slice; NumSlices*SliceSize = 128.
- IdxWidth, $clog2(NumSlices), slice index width (derived, not overridable).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- iv_load_i  input  1  load counter from iv_i (single-cycle strobe)
- iv_i  input  128  initial counter value
- incr_req_i  input  1  increment request; level, held until incr_ack_o
- incr_ack_o  output  1  one-cycle pulse: increment complete, ctr_o updated
- ctr_o  output  128  current counter value
- fsm_incr_o  output  1  launch strobe to slice FSM
- fsm_ready_i  input  1  slice FSM idle/ready
- fsm_alert_i  input  1  slice FSM in error
- slice_idx_i  input  IdxWidth  slice index selected by FSM
- slice_o  output  SliceSize  counter slice at slice_idx_i (combinational)
- slice_i  input  SliceSize  incremented slice from FSM
- slice_we_i  input  1  write slice_i to slice slice_idx_i
- err_o  output  1  sticky error

Behaviour:
- Reset values: ctr_o=0, incr_ack_o=0, fsm_incr_o=0, err_o=0; state=IDLE; saw_busy=0.
- Slice mapping: slice k = ctr bits [k*SliceSize+SliceSize-1 : k*SliceSize]; slice 0 is least significant.
- slice_o = slice(slice_idx_i), purely combinational.
- Writes: when slice_we_i=1 in WAIT, slice slice_idx_i <= slice_i at the clock edge.
- Carry and wrap are handled by the FSM. All-ones + 1 -> all-zero; carry out is discarded.

States:
- IDLE
  - iv_load_i=1: ctr <= iv_i; stay in IDLE.
  - else if incr_req_i=1: fsm_incr_o=1 this cycle; go to WAIT; clear saw_busy.
  - iv_load_i has priority over incr_req_i in the same cycle. The request stays pending and starts the following cycle.
- WAIT
  - fsm_ready_i=0 sets saw_busy.
  - saw_busy=1 and fsm_ready_i=1: incr_ack_o=1 for one cycle; go to IDLE.
  - A ready seen before any busy cycle does not complete the increment.
- ERROR
  - Terminal until reset. err_o=1, fsm_incr_o=0, incr_ack_o=0, writes ignored, ctr_o frozen.

Errors (any state -> ERROR, err_o set next cycle):
- fsm_alert_i=1.
- slice_we_i=1 in IDLE.
- iv_load_i=1 in WAIT; the load is not applied.
- Invalid state encoding.

Latency:
- Request accepted at cycle 0 (fsm_incr_o=1).
- FSM writes slices in cycles 1..NumSlices.
- incr_ack_o at cycle NumSlices+1 (9 with defaults). ctr_o already holds the new value in that cycle.

Handshake:
- After incr_ack_o, a still-asserted incr_req_i is treated as a new request in the next IDLE cycle. The requester must drop it in the ack cycle to avoid a second increment.
- Reset mid-operation: all state cleared immediately (asynchronous); counter returns to 0.

Optional Feature:
- Macro: AES_CTR_SLICE_REG_TIMEOUT_EN.
- Defined:
  - A watchdog counter is cleared on entry to WAIT and increments each cycle in WAIT.
  - If it reaches NumSlices+4 (12) without completion, go to ERROR and set err_o.
- Undefined: no watchdog; WAIT may last indefinitely.

Test Plan:
- IV load of 0x000102030405060708090A0B0C0D0E0F, then slice_idx_i=0 -> slice_o=0x0E0F; slice_idx_i=7 -> 0x0001; ctr_o equals iv_i the cycle after the load.
- incr_req_i with a behavioural FSM model (ready low for 8 cycles, writes slices 0..7 with carry) -> fsm_incr_o at cycle 0, incr_ack_o at cycle 9, ctr_o=...0E10.
- IV=all-ones, then increment -> ctr_o=0 at ack, err_o=0.
- iv_load_i and incr_req_i asserted together in IDLE -> ctr_o=iv_i next cycle, fsm_incr_o one cycle later, ack produced normally.
- slice_we_i=1 in IDLE -> err_o=1 next cycle; a subsequent incr_req_i gives no fsm_incr_o and no ack; ctr_o unchanged until rst_ni.
- Optional feature: with AES_CTR_SLICE_REG_TIMEOUT_EN defined and fsm_ready_i held low after launch -> err_o=1 after 12 cycles in WAIT; without the macro, err_o stays 0.

Source files
------------

// File: rtl/aes_ctr_slice_reg.sv
`default_nettype none
// ============================================================================
// aes_ctr_slice_reg : AES-CTR counter storage and slice-increment sequencing.
// Optional watchdog: define AES_CTR_SLICE_REG_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
module aes_ctr_slice_reg #(
   parameter  int NumSlices = 8,
   parameter  int SliceSize = 16,
   localparam int IdxWidth  = $clog2(NumSlices),
   localparam int CtrWidth  = NumSlices * SliceSize
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 iv_load_i,
   input  logic [CtrWidth-1:0]  iv_i,
   input  logic                 incr_req_i,
   output logic                 incr_ack_o,
   output logic [CtrWidth-1:0]  ctr_o,
   output logic                 fsm_incr_o,
   input  logic                 fsm_ready_i,
   input  logic                 fsm_alert_i,
   input  logic [IdxWidth-1:0]  slice_idx_i,
   output logic [SliceSize-1:0] slice_o,
   input  logic [SliceSize-1:0] slice_i,
   input  logic                 slice_we_i,
   output logic                 err_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_WAIT  = 2'b01,
      S_ERROR = 2'b10
   } state_e;

   state_e              r_state;
   logic [CtrWidth-1:0] r_ctr;
   logic                r_saw_busy;
   logic                r_err;

   logic w_in_idle;
   logic w_in_wait;
   logic w_bad_state;
   logic w_done_raw;
   logic w_timeout;
   logic w_err;
   logic w_launch;
   logic w_done;

   assign w_in_idle   = (r_state == S_IDLE);
   assign w_in_wait   = (r_state == S_WAIT);
   assign w_bad_state = !(r_state inside {S_IDLE, S_WAIT, S_ERROR});
   // Completion needs a busy cycle first so a stale ready cannot ack.
   assign w_done_raw  = w_in_wait && r_saw_busy && fsm_ready_i;

`ifdef AES_CTR_SLICE_REG_TIMEOUT_EN
   localparam int c_WDOG_LIMIT = NumSlices + 4;
   localparam int c_WDOG_W     = $clog2(c_WDOG_LIMIT + 1);

   logic [c_WDOG_W-1:0] r_wdog;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wdog <= '0;
      end else if (w_launch) begin
         r_wdog <= '0;
      end else if (w_in_wait) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign w_timeout = w_in_wait && !w_done_raw &&
                      (r_wdog == c_WDOG_W'(c_WDOG_LIMIT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign w_err = fsm_alert_i
                | (w_in_idle && slice_we_i)
                | (w_in_wait && iv_load_i)
                | w_bad_state
                | w_timeout;

   assign w_launch = w_in_idle && !iv_load_i && incr_req_i && !w_err;
   assign w_done   = w_done_raw && !w_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_ctr      <= '0;
         r_saw_busy <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_err) begin
         r_state <= S_ERROR;
         r_err   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iv_load_i) begin
                  r_ctr <= iv_i;
               end else if (incr_req_i) begin
                  r_state    <= S_WAIT;
                  r_saw_busy <= 1'b0;
               end
            end
            S_WAIT: begin
               if (!fsm_ready_i) begin
                  r_saw_busy <= 1'b1;
               end
               if (slice_we_i) begin
                  r_ctr[int'(slice_idx_i) * SliceSize +: SliceSize] <= slice_i;
               end
               if (w_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_ERROR;
            end
         endcase
      end
   end

   assign ctr_o      = r_ctr;
   assign slice_o    = r_ctr[int'(slice_idx_i) * SliceSize +: SliceSize];
   assign fsm_incr_o = w_launch;
   assign incr_ack_o = w_done;
   assign err_o      = r_err;

endmodule
`default_nettype wire
